axis_burst_initiator: RTL and testbench

AXIS_BURST_INITIATOR -- requirements
Module: axis_burst_initiator

---
 rtl/axis_burst_initiator_if.sv | 25 ++
 rtl/axis_burst_initiator.sv | 169 ++++++++++++++++
 tb/tb_axis_burst_initiator.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_burst_initiator_if.sv
// Request/response stream pair between the burst initiator and its peer.
// Latency: n/a (wires only).
// Backpressure: m_ready stalls the request stream, s_ready stalls the response stream.
interface axis_burst_initiator_if #(
    parameter int DATA_W = 8
);
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;

    modport master (
        output m_valid, m_data, m_last, s_ready,
        input  m_ready, s_valid, s_data, s_last
    );

    modport slave (
        input  m_valid, m_data, m_last, s_ready,
        output m_ready, s_valid, s_data, s_last
    );
endinterface

// File: rtl/axis_burst_initiator.sv
// Sends a TX-buffer burst on the request stream, then captures the peer's response burst into RX.
// Latency: first request beat one cycle after start; done pulses one cycle after the response ends.
// Backpressure: m_ready=0 holds the current beat; s_ready drops once RX holds DEPTH words.
module axis_burst_initiator #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [CW-1:0]         len,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    axis_burst_initiator_if.master bus,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic [CW-1:0]         rx_count
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [TW-1:0] TMO_C   = TW'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RECV, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] tx_mem [DEPTH];
    logic [DATA_W-1:0] rx_mem [DEPTH];
    logic [CW-1:0]     len_q;
    logic [CW-1:0]     idx;
    logic [TW-1:0]     tmo;
    logic [CW-1:0]     idx_nxt;
    logic [CW-1:0]     rx_nxt;
    logic [TW-1:0]     tmo_nxt;
    logic              s_beat;

    assign idx_nxt = idx + CW'(1);
    assign rx_nxt  = rx_count + CW'(1);
    assign tmo_nxt = tmo + TW'(1);
    assign s_beat  = bus.s_valid && bus.s_ready;

    // Buffers carry no reset so they map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !busy)
            tx_mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (s_beat)
            rx_mem[rx_count[AW-1:0]] <= bus.s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else
            rd_data <= rx_mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_last  <= 1'b0;
            bus.s_ready <= 1'b0;
            rx_count    <= '0;
            idx         <= '0;
            tmo         <= '0;
            len_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= len;
                        err      <= 1'b0;
                        rx_count <= '0;
                        idx      <= '0;
                        tmo      <= '0;
                        busy     <= 1'b1;
                        if (len == '0 || len > DEPTH_C) begin
                            state <= DONE;
                            err   <= 1'b1;
                            done  <= 1'b1;
                        end else begin
                            state       <= SEND;
                            bus.m_valid <= 1'b1;
                            bus.m_data  <= tx_mem[AW'(0)];
                            bus.m_last  <= (len == CW'(1));
                        end
                    end
                end
                SEND: begin
                    if (bus.m_ready) begin
                        idx <= idx_nxt;
                        if (bus.m_last) begin
                            state       <= WAIT_RESP;
                            bus.m_valid <= 1'b0;
                            bus.m_last  <= 1'b0;
                            tmo         <= '0;
                            bus.s_ready <= 1'b1;
                        end else begin
                            // Prefetch the next word so it is already stable when m_valid stays up.
                            bus.m_data <= tx_mem[idx_nxt[AW-1:0]];
                            bus.m_last <= (idx_nxt == len_q - CW'(1));
                        end
                    end
                end
                WAIT_RESP: begin
                    if (s_beat) begin
                        rx_count <= rx_nxt;
                        if (bus.s_last) begin
                            state       <= DONE;
                            bus.s_ready <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            state       <= RECV;
                            bus.s_ready <= (rx_nxt < DEPTH_C);
                        end
                    end else if (tmo_nxt >= TMO_C) begin
                        state       <= DONE;
                        err         <= 1'b1;
                        bus.s_ready <= 1'b0;
                        done        <= 1'b1;
                        tmo         <= TMO_C;
                    end else begin
                        tmo <= tmo_nxt;
                    end
                end
                RECV: begin
                    if (rx_count == DEPTH_C) begin
                        // Full: a word still offered without s_last means the response overran RX.
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= bus.s_valid && !bus.s_last;
                    end else if (!bus.s_valid) begin
                        state       <= DONE;
                        bus.s_ready <= 1'b0;
                        done        <= 1'b1;
                    end else begin
                        rx_count <= rx_nxt;
                        if (bus.s_last) begin
                            state       <= DONE;
                            bus.s_ready <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            bus.s_ready <= (rx_nxt < DEPTH_C);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_burst_initiator.sv
// Directed bench for axis_burst_initiator: request bursts, stalls, timeout, gap/full endings, reset abort.
module tb_axis_burst_initiator;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int AW      = 2;
    localparam int CW      = 3;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [CW-1:0]     len;
    logic              start;
    logic              busy;
    logic              done;
    logic              err;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [CW-1:0]     rx_count;

    axis_burst_initiator_if #(.DATA_W(DATA_W)) bus ();

    axis_burst_initiator #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .len     (len),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bus     (bus),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rx_count(rx_count)
    );

    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;
    int stall_cnt = 0;
    int d0;
    int cyc;
    logic [7:0] beat_dat [$];
    logic       beat_last [$];
    logic       stall_q = 1'b0;
    logic [7:0] stall_dat = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observe the bus mid-cycle: inputs change just after posedge, so values here are what the next edge sees.
    always @(negedge clk) begin
        if (stall_q) begin
            check("hold_vld", bus.m_valid, 1);
            check("hold_dat", bus.m_data, stall_dat);
        end
        stall_q   = bus.m_valid && !bus.m_ready;
        stall_dat = bus.m_data;
        if (stall_q)
            stall_cnt++;
        if (bus.m_valid && bus.m_ready) begin
            beat_dat.push_back(bus.m_data);
            beat_last.push_back(bus.m_last);
        end
        if (done)
            done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic do_start(input logic [CW-1:0] l);
        len   = l;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_resp(input int n, input logic [7:0] base, input bit last_final);
        for (int i = 0; i < n; i++) begin
            bit acc;
            acc         = 1'b0;
            bus.s_valid = 1'b1;
            bus.s_data  = base + 8'(i);
            bus.s_last  = last_final && (i == n - 1);
            for (int k = 0; k < 20 && !acc; k++) begin
                acc = bus.s_ready;
                step();
            end
            if (!acc)
                break;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 60; k++) begin
            if (!busy)
                break;
            step();
        end
        check(tag, busy, 0);
    endtask

    task automatic check_beats(input string tag, input int n, input logic [31:0] exp_dat,
                               input logic [3:0] exp_last);
        check({tag, "_nbeats"}, beat_dat.size(), n);
        for (int i = 0; i < n && i < beat_dat.size(); i++) begin
            check({tag, "_dat"}, beat_dat[i], exp_dat[8*i +: 8]);
            check({tag, "_last"}, beat_last[i], exp_last[i]);
        end
    endtask

    initial begin
        rst         = 1'b1;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        len         = '0;
        start       = 1'b0;
        rd_addr     = '0;
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        repeat (3) step();

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_last", bus.m_last, 0);
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_rx_count", rx_count, 0);
        check("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        step();

        // Basic 3-word request, 2-word response ending on s_last.
        host_write(2'd0, 8'h11);
        host_write(2'd1, 8'h22);
        host_write(2'd2, 8'h33);
        beat_dat.delete();
        beat_last.delete();
        bus.m_ready = 1'b1;
        d0 = done_cnt;
        do_start(3'd3);
        send_resp(2, 8'hA0, 1'b1);
        wait_idle("t1_idle");
        check_beats("t1", 3, 32'h00332211, 4'b0100);
        check("t1_rx_count", rx_count, 2);
        check("t1_err", err, 0);
        check("t1_done_pulses", done_cnt - d0, 1);
        rd_addr = 2'd0;
        step();
        check("t1_rx0", rd_data, 8'hA0);
        rd_addr = 2'd1;
        step();
        check("t1_rx1", rd_data, 8'hA1);

        // Alternating m_ready: stalled beats must hold.
        host_write(2'd0, 8'hC0);
        host_write(2'd1, 8'hC1);
        host_write(2'd2, 8'hC2);
        host_write(2'd3, 8'hC3);
        beat_dat.delete();
        beat_last.delete();
        bus.m_ready = 1'b0;
        stall_cnt   = 0;
        d0 = done_cnt;
        do_start(3'd4);
        for (int k = 0; k < 40 && beat_dat.size() < 4; k++) begin
            bus.m_ready = !bus.m_ready;
            step();
        end
        bus.m_ready = 1'b1;
        check("t2_stalls", stall_cnt, 3);
        send_resp(1, 8'hB0, 1'b1);
        wait_idle("t2_idle");
        check_beats("t2", 4, 32'hC3C2C1C0, 4'b1000);
        check("t2_done_pulses", done_cnt - d0, 1);

        // Silent peer: timeout after TIMEOUT cycles in WAIT_RESP.
        d0 = done_cnt;
        do_start(3'd1);
        for (int k = 0; k < 20; k++) begin
            if (bus.s_ready)
                break;
            step();
        end
        check("t3_wait_entered", bus.s_ready, 1);
        cyc = 0;
        for (int k = 0; k < 30 && !done; k++) begin
            step();
            cyc++;
        end
        check("t3_tmo_cycles", cyc, 8);
        check("t3_err", err, 1);
        check("t3_rx_count", rx_count, 0);
        wait_idle("t3_idle");
        check("t3_done_pulses", done_cnt - d0, 1);

        // Gap-terminated response of 3 words.
        d0 = done_cnt;
        do_start(3'd1);
        send_resp(3, 8'hD0, 1'b0);
        step();
        check("t4_done_after_gap", done, 1);
        check("t4_rx_count", rx_count, 3);
        check("t4_err", err, 0);
        wait_idle("t4_idle");
        rd_addr = 2'd2;
        step();
        check("t4_rx2", rd_data, 8'hD2);

        // Illegal lengths: 0 and DEPTH+1.
        beat_dat.delete();
        beat_last.delete();
        do_start(3'd0);
        for (int k = 0; k < 2 && !done; k++) step();
        check("t5_len0_done", done, 1);
        check("t5_len0_err", err, 1);
        wait_idle("t5_len0_idle");
        do_start(3'd5);
        for (int k = 0; k < 2 && !done; k++) step();
        check("t5_len5_done", done, 1);
        check("t5_len5_err", err, 1);
        wait_idle("t5_len5_idle");
        check("t5_no_beats", beat_dat.size(), 0);

        // Overrun: DEPTH+2 words without s_last.
        d0 = done_cnt;
        do_start(3'd1);
        send_resp(6, 8'hE0, 1'b0);
        wait_idle("t6_idle");
        check("t6_rx_count", rx_count, 4);
        check("t6_err", err, 1);
        check("t6_done_pulses", done_cnt - d0, 1);
        rd_addr = 2'd3;
        step();
        check("t6_rx3", rd_data, 8'hE3);

        // Reset after two request beats, then a clean restart.
        beat_dat.delete();
        beat_last.delete();
        bus.m_ready = 1'b1;
        d0 = done_cnt;
        do_start(3'd4);
        step();
        step();
        check("t7_two_beats", beat_dat.size(), 2);
        check("t7_vld_before_rst", bus.m_valid, 1);
        rst = 1'b1;
        #1;
        check("t7_rst_m_valid", bus.m_valid, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_s_ready", bus.s_ready, 0);
        step();
        step();
        rst = 1'b0;
        step();
        check("t7_no_done", done_cnt - d0, 0);
        beat_dat.delete();
        beat_last.delete();
        do_start(3'd4);
        send_resp(1, 8'hF0, 1'b1);
        wait_idle("t7_idle");
        check_beats("t7_restart", 4, 32'hC3C2C1C0, 4'b1000);
        check("t7_err", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
